// File: rtl/mem_hs.sv
// Unified instruction/data memory: combinational fetch port plus a
// multi-cycle valid/ready data port with sized accesses and wait states.
module mem_hs #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              d_err
);

    localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_C = 4'(LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              ready_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem_q [DEPTH];

    logic [IDX_W-1:0]  d_idx;
    logic              access;
    logic [31:0]       word_rd;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_d;
    logic              rsp_err_d;
    logic [31:0]       rsp_rdata_d;
    logic [3:0]        wr_be_d;
    logic [31:0]       wr_lane_d;
    logic              unused_bits;

    // Upper address bits beyond the array wrap silently; pc[1:0] is ignored.
    assign instr       = mem_q[pc[IDX_W+1:2]];
    assign d_idx       = addr_q[IDX_W+1:2];
    assign access      = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign unused_bits = ^{pc, addr_q};

    assign d_ready = ready_q;
    assign d_err   = err_q;
    assign d_rdata = rdata_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        word_rd   = mem_q[d_idx];
        byte_sel  = word_rd[7:0];
        half_sel  = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
        load_d    = 32'd0;
        rsp_err_d = 1'b0;
        wr_be_d   = 4'b0000;
        wr_lane_d = wdata_q;

        case (addr_q[1:0])
            2'd0:    byte_sel = word_rd[7:0];
            2'd1:    byte_sel = word_rd[15:8];
            2'd2:    byte_sel = word_rd[23:16];
            default: byte_sel = word_rd[31:24];
        endcase

        case (size_q)
            2'b00: begin
                wr_be_d   = 4'b0001 << addr_q[1:0];
                wr_lane_d = {4{wdata_q[7:0]}};
                load_d    = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                rsp_err_d = addr_q[0];
                wr_be_d   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lane_d = {2{wdata_q[15:0]}};
                load_d    = {{16{~uns_q & half_sel[15]}}, half_sel};
            end
            2'b10: begin
                rsp_err_d = (addr_q[1:0] != 2'b00);
                wr_be_d   = 4'b1111;
                load_d    = word_rd;
            end
            default: rsp_err_d = 1'b1;
        endcase

        rsp_rdata_d = (rsp_err_d || we_q) ? 32'd0 : load_d;
        if (!access || !we_q || rsp_err_d)
            wr_be_d = 4'b0000;
    end

    // NOTE: the storage array has no reset; clearing it would cost a write port per word and
    // its power-up contents are never relied on. A reset mid-transaction drops the state out
    // of WAIT asynchronously, so the write enable is already low at the next edge.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be_d[b])
                mem_q[d_idx][b*8 +: 8] <= wr_lane_d[b*8 +: 8];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                    if (d_req) begin
                        we_q    <= d_we;
                        size_q  <= d_size;
                        uns_q   <= d_unsigned;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        cnt_q   <= LAT_C;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        ready_q <= 1'b1;
                        err_q   <= rsp_err_d;
                        rdata_q <= rsp_rdata_d;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_hs.sv
// Scoreboard bench for mem_hs: a LAT=2 instance for the main checks and a
// LAT=0 instance for back-to-back throughput.
module tb_mem_hs;

    localparam int LAT = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    // LAT=2 instance signals
    logic [15:0] pc = 16'h0;
    logic [31:0] instr;
    logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
    logic [1:0]  d_size = 2'b10;
    logic [15:0] d_addr = 16'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_ready, d_err;

    // LAT=0 instance signals
    logic [15:0] z_pc = 16'h0;
    logic [31:0] z_instr;
    logic        z_req = 1'b0, z_we = 1'b0, z_unsigned = 1'b0;
    logic [1:0]  z_size = 2'b10;
    logic [15:0] z_addr = 16'h0;
    logic [31:0] z_wdata = 32'h0;
    logic [31:0] z_rdata;
    logic        z_ready, z_err;

    exp_t sb[$];
    exp_t sb0[$];
    exp_t e_m, e_z;
    logic prev_ready = 1'b0, prev_ready0 = 1'b0;

    mem_hs #(.ADDR_W(16), .DEPTH(1024), .LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ready(d_ready), .d_err(d_err)
    );

    mem_hs #(.ADDR_W(16), .DEPTH(1024), .LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .pc(z_pc), .instr(z_instr),
        .d_req(z_req), .d_we(z_we), .d_size(z_size), .d_unsigned(z_unsigned),
        .d_addr(z_addr), .d_wdata(z_wdata), .d_rdata(z_rdata),
        .d_ready(z_ready), .d_err(z_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitors: pop one expectation per d_ready pulse.
    always @(negedge clk) begin
        if (d_ready) begin
            check("ready_pulse", prev_ready, 0);
            if (sb.size() == 0) begin
                check("spurious_ready", 1, 0);
            end else begin
                e_m = sb.pop_front();
                check("rdata", d_rdata, e_m.rdata);
                check("err", d_err, e_m.err);
                check("latency", cyc, e_m.cyc);
            end
        end else begin
            check("idle_zero", {d_err, d_rdata}, 0);
        end
        prev_ready = d_ready;
    end

    always @(negedge clk) begin
        if (z_ready) begin
            check("z_ready_pulse", prev_ready0, 0);
            if (sb0.size() == 0) begin
                check("z_spurious_ready", 1, 0);
            end else begin
                e_z = sb0.pop_front();
                check("z_rdata", z_rdata, e_z.rdata);
                check("z_err", z_err, e_z.err);
                check("z_latency", cyc, e_z.cyc);
            end
        end else begin
            check("z_idle_zero", {z_err, z_rdata}, 0);
        end
        prev_ready0 = z_ready;
    end

    task automatic push_exp(input bit u0, input logic [31:0] rd, input logic er, input int at);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        e.cyc   = at;
        if (u0) sb0.push_back(e);
        else    sb.push_back(e);
    endtask

    // Drives one request on an idle DUT; returns with acc = acceptance edge index.
    task automatic start_txn(input bit u0, input logic we, input logic [1:0] size,
                             input logic uns, input logic [15:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input logic exp_err,
                             input bit want_resp, output int acc);
        int lat;
        lat = u0 ? 0 : LAT;
        @(negedge clk);
        if (u0) begin
            z_we = we; z_size = size; z_unsigned = uns; z_addr = addr; z_wdata = wdata; z_req = 1'b1;
        end else begin
            d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end
        @(posedge clk);
        #1;
        if (u0) z_req = 1'b0;
        else    d_req = 1'b0;
        acc = cyc;
        if (want_resp) push_exp(u0, exp_rd, exp_err, acc + lat + 1);
    endtask

    task automatic wait_done(input bit u0);
        for (int i = 0; i < 60; i++) begin
            if ((u0 ? sb0.size() : sb.size()) == 0) break;
            @(negedge clk);
        end
        check(u0 ? "z_drain" : "drain", u0 ? sb0.size() : sb.size(), 0);
    endtask

    task automatic txn(input bit u0, input logic we, input logic [1:0] size, input logic uns,
                       input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err);
        int acc;
        start_txn(u0, we, size, uns, addr, wdata, exp_rd, exp_err, 1'b1, acc);
        wait_done(u0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;

        // Reset state
        #1;
        check("rst_ready", d_ready, 0);
        check("rst_err", d_err, 0);
        check("rst_rdata", d_rdata, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Word store/load
        txn(0, 1, 2'b10, 0, 16'h0010, 32'hDEADBEEF, 32'h0, 0);
        txn(0, 0, 2'b10, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);

        // Byte/half lanes and extension
        txn(0, 1, 2'b10, 0, 16'h0020, 32'h11223344, 32'h0, 0);
        txn(0, 1, 2'b00, 0, 16'h0021, 32'hCCCCCC80, 32'h0, 0);
        txn(0, 0, 2'b10, 0, 16'h0020, 32'h0, 32'h11228044, 0);
        txn(0, 0, 2'b00, 0, 16'h0021, 32'h0, 32'hFFFFFF80, 0);
        txn(0, 0, 2'b00, 1, 16'h0021, 32'h0, 32'h00000080, 0);
        txn(0, 0, 2'b00, 0, 16'h0020, 32'h0, 32'h00000044, 0);
        txn(0, 0, 2'b01, 0, 16'h0020, 32'h0, 32'hFFFF8044, 0);
        txn(0, 1, 2'b01, 0, 16'h0022, 32'h1234BEEF, 32'h0, 0);
        txn(0, 0, 2'b10, 0, 16'h0020, 32'h0, 32'hBEEF8044, 0);
        txn(0, 0, 2'b01, 1, 16'h0022, 32'h0, 32'h0000BEEF, 0);
        txn(0, 0, 2'b01, 0, 16'h0022, 32'h0, 32'hFFFFBEEF, 0);
        txn(0, 0, 2'b10, 1, 16'h0020, 32'h0, 32'hBEEF8044, 0);

        // Faults: no write, zero data
        txn(0, 1, 2'b01, 0, 16'h0013, 32'h0000AAAA, 32'h0, 1);
        txn(0, 1, 2'b10, 0, 16'h0011, 32'hFFFFFFFF, 32'h0, 1);
        txn(0, 1, 2'b11, 0, 16'h0010, 32'h00000000, 32'h0, 1);
        txn(0, 0, 2'b10, 0, 16'h0012, 32'h0, 32'h0, 1);
        txn(0, 0, 2'b01, 0, 16'h0021, 32'h0, 32'h0, 1);
        txn(0, 0, 2'b11, 0, 16'h0010, 32'h0, 32'h0, 1);
        txn(0, 0, 2'b10, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);

        // Requests toggled while busy are ignored
        start_txn(0, 1, 2'b10, 0, 16'h0030, 32'h0000FACE, 32'h0, 0, 1'b1, acc);
        d_we = 1'b1; d_size = 2'b10; d_addr = 16'h0010; d_wdata = 32'h0BAD0BAD;
        for (int k = 0; k < 4; k++) begin
            d_req = (k != 1);
            @(posedge clk);
            #1;
        end
        d_req = 1'b0;
        wait_done(0);
        txn(0, 0, 2'b10, 0, 16'h0030, 32'h0, 32'h0000FACE, 0);
        txn(0, 0, 2'b10, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);

        // Reset in WAIT aborts the store
        start_txn(0, 1, 2'b10, 0, 16'h0010, 32'h12345678, 32'h0, 0, 1'b0, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", {d_ready, d_err, d_rdata}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        txn(0, 0, 2'b10, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);

        // Fetch coherence and address wrap
        txn(0, 1, 2'b10, 0, 16'h0004, 32'h0BADF00D, 32'h0, 0);
        pc = 16'h0004;
        start_txn(0, 1, 2'b10, 0, 16'h1004, 32'hA5A5A5A5, 32'h0, 0, 1'b1, acc);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("instr_old", instr, 32'h0BADF00D);
        @(negedge clk);
        check("instr_new", instr, 32'hA5A5A5A5);
        wait_done(0);
        pc = 16'h0007;
        #1;
        check("instr_lowbits", instr, 32'hA5A5A5A5);
        txn(0, 0, 2'b10, 0, 16'h0004, 32'h0, 32'hA5A5A5A5, 0);

        // LAT=0 back-to-back: held request completes every 3 cycles
        txn(1, 1, 2'b10, 0, 16'h0100, 32'h600DCAFE, 32'h0, 0);
        @(negedge clk);
        z_we = 1'b0; z_size = 2'b10; z_unsigned = 1'b0; z_addr = 16'h0100; z_req = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int k = 0; k < 4; k++) push_exp(1, 32'h600DCAFE, 1'b0, acc + 1 + 3 * k);
        repeat (9) @(posedge clk);
        #1;
        z_req = 1'b0;
        wait_done(1);
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
